// File: rtl/apb_irq_responder.sv
// APB slave holding a 4-source edge-triggered interrupt controller (pending, mask, enable).
// Define IRQ_SYNC_EN to pass the trigger lines through a 2-flop synchronizer first.
module apb_irq_responder (
    input  logic        pclk_i,
    input  logic        rst_n_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    input  logic [3:0]  irq_trigger_i,
    output logic        irq_o,
    output logic [1:0]  irq_id_o
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd1;
    localparam logic [2:0] ADDR_CLEAR   = 3'd2;
    localparam logic [2:0] ADDR_CTRL    = 3'd3;
    localparam logic [2:0] ADDR_MASK    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    apb_state_e  state_q, state_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;
    logic        wr_en_q, wr_en_d;
    logic [2:0]  wr_addr_q, wr_addr_d;
    logic [3:0]  wr_data_q, wr_data_d;

    logic [3:0]  pending_q, pending_d;
    logic        ctrl_q, ctrl_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  trig_hist_q, trig_hist_d;
    logic        irq_q, irq_d;

    logic [3:0]  trig_s;
    logic [3:0]  active;
    logic        any_active;
    logic [1:0]  active_id;
    logic        addr_err;
    logic        xfer_err;
    logic [31:0] rdata;
    logic [3:0]  clr;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^pwdata_i[31:4];

`ifdef IRQ_SYNC_EN
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq_trigger_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign trig_s = sync2_q;
`else
    assign trig_s = irq_trigger_i;
`endif

    assign active     = pending_q & ~mask_q;
    assign any_active = |active;

    // Lowest index wins: scanning downward lets the smallest set bit overwrite last.
    always_comb begin
        active_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (active[i]) active_id = 2'(i);
        end
    end

    assign addr_err = (paddr_i > 32'd4);
    assign xfer_err = addr_err || (pwrite_i && (paddr_i < 32'd2));

    always_comb begin
        rdata = '0;
        if (!addr_err) begin
            case (paddr_i[2:0])
                ADDR_PENDING: rdata[3:0] = pending_q;
                ADDR_ACTIVE: begin
                    rdata[4]   = any_active;
                    rdata[1:0] = active_id;
                end
                ADDR_CTRL:    rdata[0]   = ctrl_q;
                ADDR_MASK:    rdata[3:0] = mask_q;
                default:      rdata      = '0;
            endcase
        end
    end

    // APB protocol FSM; transfer attributes are captured on entry to ACCESS so the
    // commit at the end of ACCESS does not depend on what the bus does meanwhile.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                prdata_d  = (pwrite_i || xfer_err) ? 32'd0 : rdata;
                pslverr_d = xfer_err;
                wr_en_d   = pwrite_i && !xfer_err;
                wr_addr_d = paddr_i[2:0];
                wr_data_d = pwdata_i[3:0];
            end
            ST_ACCESS: begin
                if (psel_i && !penable_i) state_d = ST_SETUP;
                else                      state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clr    = '0;
        ctrl_d = ctrl_q;
        mask_d = mask_q;

        // wr_en_q is only ever high during ACCESS, so this commits on the edge ending it.
        if (wr_en_q) begin
            case (wr_addr_q)
                ADDR_CLEAR: clr    = wr_data_q;
                ADDR_CTRL:  ctrl_d = wr_data_q[0];
                ADDR_MASK:  mask_d = wr_data_q;
                default:    clr    = '0;
            endcase
        end

        trig_hist_d = trig_s;
        // A new rising edge is OR-ed in after the clear so it survives a same-edge clear.
        pending_d   = (pending_q & ~clr) | (trig_s & ~trig_hist_q);
        irq_d       = ctrl_q & any_active;
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            pending_q   <= '0;
            ctrl_q      <= 1'b0;
            mask_q      <= '0;
            trig_hist_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values,
            // so the order of these lines carries no meaning.
            state_q     <= state_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pending_q   <= pending_d;
            ctrl_q      <= ctrl_d;
            mask_q      <= mask_d;
            trig_hist_q <= trig_hist_d;
            irq_q       <= irq_d;
        end
    end

    assign prdata_o  = prdata_q;
    assign pslverr_o = pslverr_q;
    assign pready_o  = (state_q == ST_ACCESS);
    assign irq_o     = irq_q;
    assign irq_id_o  = active_id;

endmodule

// File: tb/tb_apb_irq_responder.sv
// Self-checking bench for apb_irq_responder: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the interrupt controller.
module tb_apb_irq_responder;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        pclk_i = 1'b0;
    logic        rst_n_i;
    logic        psel_i, penable_i, pwrite_i;
    logic [31:0] paddr_i, pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [3:0]  irq_trigger_i;
    logic        irq_o;
    logic [1:0]  irq_id_o;

    apb_irq_responder dut (
        .pclk_i        (pclk_i),
        .rst_n_i       (rst_n_i),
        .psel_i        (psel_i),
        .penable_i     (penable_i),
        .pwrite_i      (pwrite_i),
        .paddr_i       (paddr_i),
        .pwdata_i      (pwdata_i),
        .prdata_o      (prdata_o),
        .pready_o      (pready_o),
        .pslverr_o     (pslverr_o),
        .irq_trigger_i (irq_trigger_i),
        .irq_o         (irq_o),
        .irq_id_o      (irq_id_o)
    );

    always #5 pclk_i = ~pclk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    logic [3:0]  m_pending, m_mask;
    logic        m_ctrl, m_irq;
    logic [3:0]  trig_log[$];
    logic        cm_valid;
    logic [2:0]  cm_addr;
    logic [31:0] cm_data;
    bit          rand_trig = 1'b0;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [3:0] act;
        act = m_pending & ~m_mask;
        case (addr)
            32'd0:   return {28'd0, m_pending};
            32'd1:   return {27'd0, |act, 2'b00, lowest(act)};
            32'd3:   return {31'd0, m_ctrl};
            32'd4:   return {28'd0, m_mask};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the model: edge detection on the (optionally delayed) trigger
    // history, then register writes, with a new set event beating a clear.
    function automatic void model_edge();
        int         idx;
        logic [3:0] d_now, d_prev, clr;
        trig_log.push_back(irq_trigger_i);
        idx    = trig_log.size() - 1 - LAT;
        d_now  = (idx >= 0) ? trig_log[idx] : 4'd0;
        d_prev = (idx >= 1) ? trig_log[idx-1] : 4'd0;
        m_irq  = m_ctrl & |(m_pending & ~m_mask);
        clr    = 4'd0;
        if (cm_valid) begin
            case (cm_addr)
                3'd2: clr    = cm_data[3:0];
                3'd3: m_ctrl = cm_data[0];
                3'd4: m_mask = cm_data[3:0];
                default: ;
            endcase
            cm_valid = 1'b0;
        end
        m_pending = (m_pending & ~clr) | (d_now & ~d_prev);
        if (trig_log.size() > 8) void'(trig_log.pop_front());
    endfunction

    task automatic tick();
        @(posedge pclk_i);
        model_edge();
        @(negedge pclk_i);
        check("irq_o", irq_o, m_irq);
        check("irq_id", irq_id_o, lowest(m_pending & ~m_mask));
        if (rand_trig && ($urandom_range(0, 3) == 0)) irq_trigger_i = 4'($urandom);
    endtask

    // trig_stage 0/1/2 raises trigger line 3 before edge 1/2/3 of the transfer.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input int trig_stage, output logic [31:0] rdata, output logic err);
        logic [31:0] exp_rd;
        logic        exp_err;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = data;
        if (trig_stage == 0) irq_trigger_i = 4'b1000;
        tick();
        check("pready_setup", pready_o, 1'b0);
        penable_i = 1'b1;
        if (trig_stage == 1) irq_trigger_i = 4'b1000;
        exp_err = (addr > 32'd4) || (wr && (addr < 32'd2));
        exp_rd  = (wr || exp_err) ? 32'd0 : model_read(addr);
        tick();
        rdata = prdata_o;
        err   = pslverr_o;
        check("pready_access", pready_o, 1'b1);
        check("pslverr", err, exp_err);
        check("prdata", rdata, exp_rd);
        if (wr && !exp_err) begin
            cm_valid = 1'b1;
            cm_addr  = addr[2:0];
            cm_data  = data;
        end
        if (trig_stage == 2) irq_trigger_i = 4'b1000;
        tick();
        check("pready_idle", pready_o, 1'b0);
        check("prdata_idle", prdata_o, 32'd0);
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd_unused;
        logic        err_unused;
        apb(1'b1, addr, data, -1, rd_unused, err_unused);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        logic err_unused;
        apb(1'b0, addr, 32'd0, -1, data, err_unused);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        #1;
        check("rst_prdata", prdata_o, 32'd0);
        check("rst_pready", pready_o, 1'b0);
        check("rst_pslverr", pslverr_o, 1'b0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_irq_id", irq_id_o, 2'd0);
        psel_i = 1'b0; penable_i = 1'b0;
        m_pending = '0; m_mask = '0; m_ctrl = 1'b0; m_irq = 1'b0;
        cm_valid = 1'b0;
        trig_log.delete();
        @(negedge pclk_i);
        @(negedge pclk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          n;

        rst_n_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = '0; pwdata_i = '0; irq_trigger_i = '0; cm_valid = 1'b0; cm_addr = '0; cm_data = '0;
        #2;
        do_reset();

        // CTRL write then readback
        wr(32'd3, 32'd1);
        rd(32'd3, d);
        check("ctrl_rd", d, 32'h1);

        // Trigger-to-pending latency, then a held-high line must not re-set after clear
        irq_trigger_i = 4'b0100;
        n = 0;
        while (n < 10) begin
            tick();
            n++;
            if (irq_id_o == 2'd2) break;
        end
        check("lat_pending", n, 1 + LAT);
        check("lat_irq_lo", irq_o, 1'b0);
        tick();
        check("lat_irq_hi", irq_o, 1'b1);
        wr(32'd2, 32'hF);
        tick();
        rd(32'd0, d);
        check("held_no_reset", d, 32'h0);
        irq_trigger_i = 4'b0000;
        repeat (3) tick();

        // Pulses on lines 1 and 0
        irq_trigger_i = 4'b0010; tick(); irq_trigger_i = 4'b0000;
        repeat (4) tick();
        rd(32'd0, d);
        check("pend_0x2", d, 32'h2);
        check("irq_pulse1", irq_o, 1'b1);
        check("id_pulse1", irq_id_o, 2'd1);
        irq_trigger_i = 4'b0001; tick(); irq_trigger_i = 4'b0000;
        repeat (4) tick();
        rd(32'd0, d);
        check("pend_0x3", d, 32'h3);
        check("id_pulse0", irq_id_o, 2'd0);

        // Masking
        wr(32'd4, 32'h1);
        check("id_mask1", irq_id_o, 2'd1);
        rd(32'd1, d);
        check("active_0x11", d, 32'h11);
        wr(32'd4, 32'h3);
        tick();
        check("irq_mask3", irq_o, 1'b0);
        rd(32'd1, d);
        check("active_0x00", d, 32'h0);
        wr(32'd4, 32'h0);
        tick();

        // Clear, then clear coinciding with a new rising edge on line 3
        check("clr_irq_before", irq_o, 1'b1);
        wr(32'd2, 32'hF);
        check("clr_irq_lag", irq_o, 1'b1);
        tick();
        check("clr_irq", irq_o, 1'b0);
        rd(32'd0, d);
        check("clr_pend", d, 32'h0);
        apb(1'b1, 32'd2, 32'hF, 2 - LAT, d, e);
        rd(32'd0, d);
        check("set_wins", d, 32'h8);
        irq_trigger_i = 4'b0000;
        tick();

        // Error transfers change nothing
        apb(1'b1, 32'd0, 32'hF, -1, d, e);
        check("err_wr0", e, 1'b1);
        apb(1'b1, 32'd1, 32'hF, -1, d, e);
        check("err_wr1", e, 1'b1);
        apb(1'b0, 32'd5, 32'd0, -1, d, e);
        check("err_rd5", e, 1'b1);
        check("err_rd5_data", d, 32'h0);
        apb(1'b1, 32'd5, 32'hF, -1, d, e);
        apb(1'b0, 32'hFFFF_FFFF, 32'd0, -1, d, e);
        check("err_rd_max", e, 1'b1);
        rd(32'd0, d);
        check("err_pend_kept", d, 32'h8);
        rd(32'd3, d);
        check("err_ctrl_kept", d, 32'h1);

        // Randomized traffic against the model
        rand_trig = 1'b1;
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 2))
                0: rd($urandom_range(0, 6), d);
                1: wr($urandom_range(0, 5), $urandom);
                default: repeat ($urandom_range(1, 3)) tick();
            endcase
        end
        rand_trig = 1'b0;
        irq_trigger_i = 4'b0000;
        repeat (4) tick();

        // Reset during ACCESS of a CTRL=1 write, trigger line 1 held high across reset
        wr(32'd3, 32'd0);
        irq_trigger_i = 4'b0010;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'd3; pwdata_i = 32'd1;
        tick();
        penable_i = 1'b1;
        tick();
        check("abort_in_access", pready_o, 1'b1);
        do_reset();
        repeat (LAT + 2) tick();
        check("held_at_release", irq_id_o, 2'd1);
        rd(32'd3, d);
        check("ctrl_after_abort", d, 32'h0);
        irq_trigger_i = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
